dco_freq_meter: RTL

DCO_FREQ_METER -- requirements
Module: dco_freq_meter

---
 rtl/dco_freq_meter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dco_freq_meter.sv
// DCO frequency meter: measures the half-period of a square wave coming from a
// DCO and recovers its control code. Edges are counted in clk cycles. Repeated
// identical measurements declare lock, and a silent input raises no_signal.
module dco_freq_meter #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sig_in,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       locked,
  output logic       no_signal,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int              MW       = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LEN_DEF = CNT_W'(51);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);

  state_t           state;
  logic             sync1, sync2, prev;
  logic             edge_p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prev_len;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_next;
  logic             len_legal;
  logic [7:0]       len_code;

  // Any transition of the synchronized input is one edge pulse.
  assign edge_p    = sync2 ^ prev;
  assign state_dbg = state;

  // Map the length of the half-period that just ended to a DCO code.
  // Lengths 4..11 select one code bit and 51 is the default (all-zero) rate.
  always_comb begin
    len_legal = 1'b0;
    len_code  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (cnt == CNT_W'(i + 4)) begin
        len_legal = 1'b1;
        len_code  = 8'(1 << i);
      end
    end
    if (cnt == LEN_DEF) begin
      len_legal = 1'b1;
      len_code  = 8'h00;
    end
  end

  // Run length of identical legal measurements, including the one completing now.
  always_comb begin
    if (cnt == prev_len) begin
      match_next = (match_cnt >= LOCK_V) ? LOCK_V : match_cnt + MW'(1);
    end else begin
      match_next = MW'(1);
    end
  end

  // Synchronizer, half-period counter, and the measurement FSM with its outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev       <= 1'b0;
      cnt        <= '0;
      prev_len   <= '0;
      match_cnt  <= '0;
      state      <= IDLE;
      code       <= 8'h00;
      code_valid <= 1'b0;
      locked     <= 1'b0;
      no_signal  <= 1'b0;
      err        <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sync2;
      err   <= 1'b0;
      if (!ena) begin
        // Disabled: forget the measurement and keep code / no_signal as they are.
        state      <= IDLE;
        cnt        <= '0;
        match_cnt  <= '0;
        locked     <= 1'b0;
        code_valid <= 1'b0;
      end else begin
        if (edge_p) begin
          cnt <= CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + CNT_W'(1);
        end
        case (state)
          IDLE: begin
            // The first edge only starts the count; no measurement exists yet.
            if (edge_p) begin
              state     <= TRACK;
              no_signal <= 1'b0;
            end
          end
          TRACK, LOCKED: begin
            // An edge wins over a timeout that lands in the same cycle.
            if (edge_p) begin
              if (len_legal) begin
                code       <= len_code;
                code_valid <= 1'b1;
                prev_len   <= cnt;
                match_cnt  <= match_next;
                if (match_next == LOCK_V) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end else begin
                  state  <= TRACK;
                  locked <= 1'b0;
                end
              end else begin
                err        <= 1'b1;
                code_valid <= 1'b0;
                match_cnt  <= '0;
                state      <= TRACK;
                locked     <= 1'b0;
              end
            end else if (cnt == TO_VAL) begin
              state      <= IDLE;
              no_signal  <= 1'b1;
              code_valid <= 1'b0;
              locked     <= 1'b0;
              match_cnt  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
